// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage (S_HALT exists only with FETCH_HALT_DETECT_EN)
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;
    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
`ifdef FETCH_HALT_DETECT_EN
        , S_HALT
`endif
    } fetch_state_t;
endpackage

// File: rtl/retire_counter.sv
// retire_counter: enable-driven wrapping counter of retired instructions
module retire_counter
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [XLEN-1:0] cnt
);
    // count one per enabled cycle, wrapping naturally at the top
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC register, imem request/response FSM and retire tracking (optional self-loop halt via FETCH_HALT_DETECT_EN)
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    input  logic            inst_ready,
    output logic            misaligned,
    output logic [XLEN-1:0] retire_cnt
`ifdef FETCH_HALT_DETECT_EN
    ,
    output logic            halted
`endif
);
    fetch_state_t state;
    logic         retire;

    // status outputs are pure state decodes so no input reaches them combinationally
    always_comb begin
        imem_req_valid = state == S_REQ;
        inst_valid     = state == S_HOLD;
        misaligned     = state == S_FAULT;
        imem_req_addr  = pc;
        retire         = state == S_HOLD && inst_ready;
`ifdef FETCH_HALT_DETECT_EN
        halted         = state == S_HALT;
`endif
    end

    // fetch FSM with PC and captured-instruction registers; fault and halt are terminal
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            inst  <= '0;
        end else begin
            case (state)
                S_REQ:  if (imem_req_ready) state <= S_WAIT;
                S_WAIT: if (imem_rsp_valid) begin
                    inst  <= imem_rsp_data;
                    state <= S_HOLD;
                end
                S_HOLD: if (inst_ready) begin
                    pc <= next_pc;
`ifdef FETCH_HALT_DETECT_EN
                    state <= (next_pc[1:0] != 2'b00) ? S_FAULT : (next_pc == pc) ? S_HALT : S_REQ;
`else
                    state <= (next_pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
`endif
                end
                default: state <= state;
            endcase
        end

    retire_counter u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (retire),
        .cnt (retire_cnt)
    );
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the single-cycle RISC-V core. Holds the architectural PC, issues one instruction-memory read per instruction over a ready/valid request channel, and presents the returned instruction with its PC to decode/execute. When the core retires the instruction, it loads the target from the `next_pc` stage, which computes it combinationally from this block's `pc` output. The block also detects misaligned targets, counts retired instructions, and optionally detects a self-loop halt.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `next_pc` in 32: target of the instruction currently at `pc`, from the `next_pc` stage.
- `imem_req_valid` out 1: read request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: read address; always equals `pc`.
- `imem_rsp_valid` in 1: read data valid. No backpressure on this channel.
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: `inst`/`pc` are valid for execute.
- `inst` out 32: captured instruction.
- `pc` out 32: current PC.
- `inst_ready` in 1: core retires the instruction this cycle; `next_pc` is valid.
- `misaligned` out 1: sticky; a target with bits `[1:0]` not equal to 0 was retired to.
- `retire_cnt` out 32: count of retired instructions.
- `halted` out 1: self-loop detected. Present only with `FETCH_HALT_DETECT_EN`.

## Operation
- FSM states: `S_REQ`, `S_WAIT`, `S_HOLD`, `S_FAULT`, plus `S_HALT` under the macro.
- `S_REQ`:
  - Drives `imem_req_valid=1`.
  - On `imem_req_ready`, moves to `S_WAIT`.
  - `imem_req_addr` must stay stable while valid and not ready.
- `S_WAIT`: on `imem_rsp_valid`, registers `imem_rsp_data` into `inst` and moves to `S_HOLD`.
- `S_HOLD`:
  - `inst_valid=1`.
  - On `inst_ready`: `pc <= next_pc` and `retire_cnt <= retire_cnt + 1`.
  - Next state is `S_FAULT` if `next_pc[1:0]` is not 0, else `S_HALT` if halt is detected, else `S_REQ`.
- `S_FAULT`:
  - Terminal: `misaligned=1`, `pc` holds the offending target.
  - No requests are issued, `inst_valid=0`.
  - Left only by reset.
- `S_HALT` (macro only):
  - Entered when `next_pc == pc` at retire.
  - Terminal: `halted=1`, no requests issued, `inst_valid=0`.
  - `retire_cnt` includes the looping instruction once.
- `imem_rsp_valid` outside `S_WAIT` is ignored (no capture, no state change).
- `inst_ready` outside `S_HOLD` is ignored.
- `retire_cnt` is 32-bit unsigned and wraps from `32'hFFFF_FFFF` to 0.
- Misaligned check takes priority over halt check.
- The imem is reset by the same `rst`, so no stale response survives a reset.

## Timing
- Reset values:
  - State `S_REQ`, `pc=RESET_PC`, `inst=0`.
  - `inst_valid=0`, `imem_req_valid=1` (combinational from state).
  - `misaligned=0`, `retire_cnt=0`, `halted=0`.
- Reset asserted mid-operation (any state): outputs take reset values immediately (asynchronous). The first request is presented in the first cycle after deassertion.
- Per-instruction minimum latency is 3 cycles: request accepted in cycle N; response earliest N+1; `inst_valid` in N+2; retire earliest N+2; new request in N+3.
- `imem_req_valid`, `inst_valid`, `misaligned` and `halted` are decoded from registered state, with no combinational path from inputs.
- `pc`, `inst` and `retire_cnt` update only on the retire edge (except `inst` on capture) and are stable otherwise.
- Response and retire in the same cycle cannot occur, because they belong to different states.

## Configuration
- `FETCH_HALT_DETECT_EN` defined:
  - `S_HALT` and the `halted` port exist.
  - Retiring with `next_pc == pc` stops fetch.
- `FETCH_HALT_DETECT_EN` undefined:
  - No `halted` port and no `S_HALT`.
  - A self-loop keeps fetching the same address indefinitely, and `retire_cnt` keeps incrementing.

## Structure
- Package `fetch_pkg` holds:
  - The state enum `fetch_state_t`.
  - `XLEN=32`.
  - The default reset PC constant `FETCH_RESET_PC`.
- Sub-module `retire_counter`: enable-driven 32-bit wrapping counter with asynchronous reset. FSM and PC register stay in `inst_fetch`.

## Test plan
- Reset, then `imem_req_ready=1`, rsp one cycle later with `32'h0000_0013`, `next_pc=32'h4` → `imem_req_addr=0`, `inst_valid` with `inst=32'h13, pc=0`, then a request at `32'h4`, `retire_cnt=1`.
- Hold `imem_req_ready=0` for 5 cycles → `imem_req_valid=1` and `imem_req_addr` stable for all 5 cycles; no state change.
- Retire with `next_pc=32'h0000_0102` → `misaligned=1`, `pc=32'h102`; no further requests for 10 cycles, even with `inst_ready` pulsed.
- With the macro, `pc=32'h94`, retire with `next_pc=32'h94` → `halted=1`, `retire_cnt` incremented once, `imem_req_valid=0`. Without the macro, the same stimulus re-requests `32'h94`.
- Assert `rst` in `S_WAIT` with a response pending → immediately `pc=RESET_PC`, `inst_valid=0`; a spurious `imem_rsp_valid` after deassertion is ignored.
- Force `retire_cnt=32'hFFFF_FFFF`, then retire one instruction → `retire_cnt=0`.
